// File: rtl/child_status_collector.sv
// child_status_collector: round-robin collector of per-child status records into one upstream buffer.
// Optional up_parity output is built only when CHILD_STATUS_COLLECTOR_PARITY_EN is defined.
module child_status_collector #(
  parameter int NUM_CHILD = 10,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        up_valid,
  input  logic                        up_ready,
  output logic [DATA_W-1:0]           up_data,
  output logic [3:0]                  up_src,
  input  logic                        clear_seen,
  output logic                        all_seen,
  output logic [15:0]                 rsp_count
`ifdef CHILD_STATUS_COLLECTOR_PARITY_EN
  ,
  output logic                        up_parity
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                r_state, w_state_next;
  logic [DATA_W-1:0]     r_data;
  logic [3:0]            r_src;
  logic [3:0]            r_ptr;
  logic [NUM_CHILD-1:0]  r_seen;
  logic                  r_all_seen;
  logic [15:0]           r_cnt;
  logic                  w_load;
  logic                  w_any;
  logic                  w_grant;
  logic [NUM_CHILD-1:0]  w_rot;
  logic [3:0]            w_off;
  logic [4:0]            w_sum;
  logic [3:0]            w_gnt_idx;
  logic [DATA_W-1:0]     w_gnt_data;
  logic [NUM_CHILD-1:0]  w_onehot;
  logic [3:0]            w_ptr_next;
  logic [NUM_CHILD-1:0]  w_seen_next;
  assign w_load  = (r_state == EMPTY) || up_ready;
  assign w_any   = |child_valid;
  assign w_grant = w_load && w_any;
  // Rotate so bit k is child (ptr+k) mod N; lowest set bit is the round-robin winner.
  assign w_rot = NUM_CHILD'({child_valid, child_valid} >> r_ptr);
  always_comb begin
    w_off = '0;
    for (int k = NUM_CHILD - 1; k >= 0; k--)
      if (w_rot[k]) w_off = 4'(k);
  end
  assign w_sum      = 5'(r_ptr) + 5'(w_off);
  assign w_gnt_idx  = (w_sum >= 5'(NUM_CHILD)) ? 4'(w_sum - 5'(NUM_CHILD)) : w_sum[3:0];
  assign w_onehot   = NUM_CHILD'(1) << w_gnt_idx;
  assign w_ptr_next = (w_gnt_idx == 4'(NUM_CHILD - 1)) ? 4'd0 : w_gnt_idx + 4'd1;
  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < NUM_CHILD; k++)
      if (w_gnt_idx == 4'(k)) w_gnt_data = child_data[k*DATA_W +: DATA_W];
  end
  assign w_seen_next = (clear_seen ? '0 : r_seen) | (w_grant ? w_onehot : '0);
  assign child_ready = (w_grant && rst_n) ? w_onehot : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_next;
  always_comb
    w_state_next = w_load ? (w_any ? FULL : EMPTY) : r_state;
  always_comb begin
    up_valid  = (r_state == FULL);
    up_data   = r_data;
    up_src    = r_src;
    all_seen  = r_all_seen;
    rsp_count = r_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (w_grant) begin
      r_data <= w_gnt_data;
      r_src  <= w_gnt_idx;
      r_ptr  <= w_ptr_next;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_seen     <= '0;
      r_all_seen <= 1'b0;
    end else begin
      r_seen     <= w_seen_next;
      r_all_seen <= &w_seen_next;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                       r_cnt <= '0;
    else if (up_valid && up_ready && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
`ifdef CHILD_STATUS_COLLECTOR_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       r_par <= 1'b0;
    else if (w_grant) r_par <= ^{w_gnt_idx, w_gnt_data};
  assign up_parity = r_par;
`endif
endmodule

// File: doc/child_status_collector.md
CHILD_STATUS_COLLECTOR -- requirements
Module: child_status_collector

Interface
REQ-001 Parameter NUM_CHILD, default 10, SHALL set the number of child instances whose status records are collected (legal range 2..16).
REQ-002 Parameter DATA_W, default 8, SHALL set the width of each child status record.
REQ-003 clk  input  1  SHALL be the single clock; all state updates SHALL occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 child_valid  input  NUM_CHILD  SHALL carry per-child record-valid, bit i belonging to child i.
REQ-006 child_data  input  NUM_CHILD*DATA_W  SHALL carry child i's record on bits [i*DATA_W +: DATA_W].
REQ-007 child_ready  output  NUM_CHILD  SHALL be per-child accept, one-hot or zero.
REQ-008 up_valid  output  1  SHALL flag a held upstream record.
REQ-009 up_ready  input  1  SHALL be upstream accept.
REQ-010 up_data  output  DATA_W  SHALL be the held record.
REQ-011 up_src  output  4  SHALL be the index of the child that supplied up_data.
REQ-012 clear_seen  input  1  SHALL be a one-cycle pulse that clears the seen mask.
REQ-013 all_seen  output  1  SHALL flag that every child has delivered at least one record since the last clear.
REQ-014 rsp_count  output  16  SHALL count completed upstream handshakes.

Function
REQ-015 The output buffer SHALL be a two-state FSM: EMPTY (up_valid=0) and FULL (up_valid=1).
REQ-016 Load condition SHALL be: state EMPTY, or state FULL with up_ready=1 in the same cycle.
REQ-017 On load with any child_valid set, a round-robin winner SHALL be chosen, its child_ready bit driven 1 combinationally, and its data/index registered; the state SHALL be FULL next cycle.
REQ-018 On load with no child_valid set, the state SHALL go to (or stay) EMPTY; child_ready SHALL be all-zero.
REQ-019 child_ready SHALL be all-zero whenever the load condition is false.
REQ-020 Latency from a child handshake to up_valid SHALL be exactly one cycle; a sustained back-to-back throughput of one record per cycle SHALL be supported.
REQ-021 up_data and up_src SHALL be stable while up_valid=1 and up_ready=0.
REQ-022 Round-robin pointer SHALL reset to 0; after granting child i the highest priority SHALL be child (i+1) mod NUM_CHILD, wrapping NUM_CHILD-1 to 0.
REQ-023 On a grant to child i, seen-mask bit i SHALL set; all_seen SHALL be 1 while all NUM_CHILD bits are set and is registered (valid the cycle after the final bit sets).
REQ-024 clear_seen coincident with a grant SHALL clear all bits except the granted bit, which SHALL be set.
REQ-025 rsp_count SHALL increment by 1 on each cycle with up_valid=1 and up_ready=1, saturating at 0xFFFF.

Reset
REQ-026 Asserting rst_n low SHALL immediately force: state EMPTY, up_valid=0, up_data=0, up_src=0, pointer=0, seen mask=0, all_seen=0, rsp_count=0, child_ready=0.
REQ-027 A record held mid-transfer when reset asserts SHALL be discarded; no handshake SHALL complete in the reset-release cycle's preceding low period.
REQ-028 Reset deassertion SHALL be taken synchronously by the integrating design; the block SHALL resume at the first rising edge with rst_n=1.

Configuration
REQ-029 With macro CHILD_STATUS_COLLECTOR_PARITY_EN defined, an output up_parity (1 bit) SHALL present the even parity of {up_src, up_data}, registered with up_data and reset to 0.
REQ-030 Without CHILD_STATUS_COLLECTOR_PARITY_EN, up_parity SHALL not exist and no parity logic SHALL be built.

Verification
REQ-031 Reset, then child_valid=0x3FF with child i data=0x10+i and up_ready=1 for 10 cycles -> up_src sequence 0,1,...,9, up_data 0x10..0x19, rsp_count=10, all_seen=1.
REQ-032 Only child 9 valid and granted, then children 0 and 9 valid -> next grant child 0 (pointer wrap).
REQ-033 up_valid=1 with up_ready=0 for 5 cycles while children 2 and 3 are valid -> up_data/up_src unchanged, child_ready=0 throughout.
REQ-034 clear_seen pulsed in the same cycle as a grant to child 4 after all_seen=1 -> seen mask=0x010, all_seen=0 next cycle.
REQ-035 Preload rsp_count to 0xFFFE via 65534 transfers, then 3 more transfers -> rsp_count=0xFFFF.
REQ-036 rst_n low for one half-cycle while FULL -> up_valid=0 immediately, with no clock edge required.
